mem_arb_rr: RTL and testbench
=============================

Name: mem_arb_rr

Overview:
- Round-robin arbiter that shares one memory port between NumInp requesters. The shared port is the input side of a banked memory splitter.
- Requests pass through combinationally, with zero added latency.
- Read and write responses return in order. An ID FIFO of winner indices routes each response back to the requester that issued it.
- The number of in-flight transactions is capped at MaxTrans.

Parameters:
- NumInp, 2, number of requesters; must be >=1.
- AddrWidth, 32, address width in bits.
- DataWidth, 32, data width in bits; power of two, >=8.
- MaxTrans, 4, maximum outstanding transactions; ID FIFO depth; must be >=1.
- IdxWidth, max(1,$clog2(NumInp)), derived; do not override.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active high.
- inp_req_i  in  NumInp  request valid, per requester.
- inp_gnt_o  out  NumInp  request granted, per requester.
- inp_addr_i  in  NumInp x AddrWidth  byte address.
- inp_wdata_i  in  NumInp x DataWidth  write data.
- inp_strb_i  in  NumInp x DataWidth/8  write strobe.
- inp_we_i  in  NumInp  write enable.
- inp_rvalid_o  out  NumInp  response valid, one-hot or zero.
- inp_rdata_o  out  DataWidth  response data, broadcast to all requesters.
- oup_req_o  out  1  shared-port request.
- oup_gnt_i  in  1  shared-port grant.
- oup_addr_o / oup_wdata_o / oup_strb_o / oup_we_o  out  AddrWidth / DataWidth / DataWidth/8 / 1  request payload.
- oup_rvalid_i  in  1  response valid; in order; one per granted request, reads and writes alike.
- oup_rdata_i  in  DataWidth  response data.
- busy_o  out  1  high while outstanding count != 0.
- err_o  out  1  sticky flag: a response arrived with no transaction outstanding.

Behaviour:
- Reset values: rr pointer=0, outstanding count=0, ID FIFO empty, lock=0, err_o=0. All outputs are 0 during reset except payload outputs, which are don't-care.
- Arbitration (combinational):
  - The winner is the first requester with inp_req_i set, searching from the rr pointer upward and wrapping at NumInp-1.
  - oup_req_o = any(inp_req_i) & (count < MaxTrans).
  - The oup_* payload is taken from the winner.
  - inp_gnt_o[w] = oup_req_o & oup_gnt_i.
- Lock:
  - If oup_req_o=1 and oup_gnt_i=0, a lock flop records the winner. The next cycle selects the locked requester irrespective of the pointer.
  - Requesters must hold req and payload stable until granted. A requester that drops req while locked is a protocol violation: lock releases, with no guaranteed behaviour.
  - Lock clears on handshake.
- On handshake (oup_req_o & oup_gnt_i):
  - rr pointer := (w+1) mod NumInp.
  - Push w into the ID FIFO.
  - count += 1.
- On oup_rvalid_i with FIFO non-empty:
  - Pop the FIFO head h.
  - inp_rvalid_o[h]=1 in the same cycle.
  - inp_rdata_o=oup_rdata_i.
  - count -= 1.
- Simultaneous handshake and response:
  - count unchanged.
  - Push and pop both happen.
  - With an empty FIFO, the response is not matched to the new push: err_o sets and the push still happens.
- Full (count==MaxTrans): oup_req_o=0, all inp_gnt_o=0. A response arriving in the same cycle frees a slot from the next cycle only, with no fall-through.
- oup_rvalid_i with FIFO empty: the response is dropped, inp_rvalid_o stays 0, err_o:=1 until reset.
- Response latency: 0 cycles; the path from oup_rvalid_i to inp_rvalid_o is combinational.
- Reset mid-operation: outstanding IDs are discarded. Responses arriving after reset release are dropped and set err_o.
- NumInp==1: the pointer is constant 0 and the FIFO still tracks count.

Optional Feature:
- Macro COMMON_CELLS_MEM_ARB_STALL_CNT_EN.
- Defined: adds output stall_cnt_o[15:0], a saturating counter.
  - Increments each cycle that any(inp_req_i) & !(oup_req_o & oup_gnt_i).
  - Holds at 16'hFFFF.
  - Reset to 0.
- Undefined: stall_cnt_o exists but is tied to 16'h0, so the port list is stable and no counter logic is generated.

Test Plan:
- NumInp=3, all req held high, oup_gnt_i=1 every cycle -> grants to requesters 0,1,2,0,1,2 on consecutive cycles; busy_o=1 after the first cycle.
- Requesters 1 and 2 request, oup_gnt_i=0 for 3 cycles then 1 -> oup_addr_o stays = inp_addr_i[1] throughout; inp_gnt_o=3'b010 on grant cycle; the next grant goes to 2.
- MaxTrans=4, gnt always 1, no rvalid -> 4 grants, then oup_req_o=0. One rvalid with rdata=32'hDEAD_BEEF -> inp_rvalid_o goes to the first winner with that data; the fifth grant occurs the following cycle.
- Interleaved: grants to requesters 2,0,1; responses 3 cycles later with data A,B,C -> inp_rvalid_o = 3'b100 (data A), then 3'b001 (data B), then 3'b010 (data C); busy_o falls after the last response.
- oup_rvalid_i pulsed with count=0 -> no inp_rvalid_o; err_o=1 and held. Assert rst_i mid-burst with 2 outstanding -> count=0, err_o=0; 2 late responses set err_o.
- Macro defined, req high with gnt low for 70000 cycles -> stall_cnt_o=16'hFFFF; macro undefined -> stall_cnt_o=0.

Source files
------------

// File: rtl/mem_arb_rr.sv
// Round-robin arbiter sharing one memory port between NumInp requesters, with in-order response routing.
// Optional saturating stall counter enabled by COMMON_CELLS_MEM_ARB_STALL_CNT_EN.
module mem_arb_rr #(
  parameter int unsigned NumInp    = 2,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned MaxTrans  = 4,
  parameter int unsigned IdxWidth  = (NumInp > 1) ? $clog2(NumInp) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NumInp-1:0]               inp_req_i,
  output logic [NumInp-1:0]               inp_gnt_o,
  input  logic [NumInp*AddrWidth-1:0]     inp_addr_i,
  input  logic [NumInp*DataWidth-1:0]     inp_wdata_i,
  input  logic [NumInp*(DataWidth/8)-1:0] inp_strb_i,
  input  logic [NumInp-1:0]               inp_we_i,
  output logic [NumInp-1:0]               inp_rvalid_o,
  output logic [DataWidth-1:0]            inp_rdata_o,
  output logic                            oup_req_o,
  input  logic                            oup_gnt_i,
  output logic [AddrWidth-1:0]            oup_addr_o,
  output logic [DataWidth-1:0]            oup_wdata_o,
  output logic [DataWidth/8-1:0]          oup_strb_o,
  output logic                            oup_we_o,
  input  logic                            oup_rvalid_i,
  input  logic [DataWidth-1:0]            oup_rdata_i,
  output logic                            busy_o,
  output logic                            err_o,
  output logic [15:0]                     stall_cnt_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned CntWidth  = $clog2(MaxTrans + 1);
  localparam int unsigned PtrWidth  = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;

  logic [IdxWidth-1:0] ptr_q, ptr_d, lock_idx_q, lock_idx_d, win, head;
  logic                lock_q, lock_d, err_q, err_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [IdxWidth-1:0] fifo_q [MaxTrans];
  logic                any_req, found, hs, pop;

  // Winner: a still-requesting locked index first, then indices >= ptr, then the wrap-around.
  // NOTE: every always_comb output gets a default up front so no path can infer a latch.
  always_comb begin
    any_req = |inp_req_i;
    win     = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NumInp; i++) begin
      if (!found && lock_q && inp_req_i[i] && lock_idx_q == IdxWidth'(i)) begin
        found = 1'b1;
        win   = IdxWidth'(i);
      end
    end
    for (int unsigned i = 0; i < NumInp; i++) begin
      if (!found && inp_req_i[i] && IdxWidth'(i) >= ptr_q) begin
        found = 1'b1;
        win   = IdxWidth'(i);
      end
    end
    for (int unsigned i = 0; i < NumInp; i++) begin
      if (!found && inp_req_i[i]) begin
        found = 1'b1;
        win   = IdxWidth'(i);
      end
    end
  end

  assign oup_req_o = any_req && (cnt_q < CntWidth'(MaxTrans)) && !rst_i;
  assign hs        = oup_req_o && oup_gnt_i;
  assign pop       = oup_rvalid_i && (cnt_q != '0);
  assign head      = fifo_q[rd_ptr_q];
  assign busy_o    = (cnt_q != '0);
  assign err_o     = err_q;
  assign inp_rdata_o = rst_i ? '0 : oup_rdata_i;

  always_comb begin
    oup_addr_o   = '0;
    oup_wdata_o  = '0;
    oup_strb_o   = '0;
    oup_we_o     = 1'b0;
    inp_gnt_o    = '0;
    inp_rvalid_o = '0;
    for (int unsigned i = 0; i < NumInp; i++) begin
      if (win == IdxWidth'(i)) begin
        oup_addr_o   = inp_addr_i[i*AddrWidth +: AddrWidth];
        oup_wdata_o  = inp_wdata_i[i*DataWidth +: DataWidth];
        oup_strb_o   = inp_strb_i[i*StrbWidth +: StrbWidth];
        oup_we_o     = inp_we_i[i];
        inp_gnt_o[i] = hs;
      end
      inp_rvalid_o[i] = pop && (head == IdxWidth'(i));
    end
  end

  always_comb begin
    ptr_d      = ptr_q;
    lock_d     = 1'b0;
    lock_idx_d = lock_idx_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    err_d      = err_q | (oup_rvalid_i && cnt_q == '0);
    if (hs) begin
      ptr_d    = (win == IdxWidth'(NumInp - 1)) ? '0 : win + 1'b1;
      wr_ptr_d = (wr_ptr_q == PtrWidth'(MaxTrans - 1)) ? '0 : wr_ptr_q + 1'b1;
    end else if (oup_req_o) begin
      lock_d     = 1'b1;
      lock_idx_d = win;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrWidth'(MaxTrans - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    // The count is the FIFO fill level, so an unmatched response never decrements it.
    case ({hs, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  // NOTE: ID storage is left unreset; entries are only read below the fill level set by cnt_q.
  always_ff @(posedge clk_i) begin
    if (hs) fifo_q[wr_ptr_q] <= win;
  end

`ifdef COMMON_CELLS_MEM_ARB_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (any_req && !hs && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = 16'h0;
`endif

endmodule

// File: tb/tb_mem_arb_rr.sv
// Directed self-checking bench for mem_arb_rr with three requesters and four outstanding transactions.
module tb_mem_arb_rr;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [2:0]   inp_req_i;
  logic [2:0]   inp_gnt_o;
  logic [95:0]  inp_addr_i;
  logic [95:0]  inp_wdata_i;
  logic [11:0]  inp_strb_i;
  logic [2:0]   inp_we_i;
  logic [2:0]   inp_rvalid_o;
  logic [31:0]  inp_rdata_o;
  logic         oup_req_o;
  logic         oup_gnt_i;
  logic [31:0]  oup_addr_o;
  logic [31:0]  oup_wdata_o;
  logic [3:0]   oup_strb_o;
  logic         oup_we_o;
  logic         oup_rvalid_i;
  logic [31:0]  oup_rdata_i;
  logic         busy_o;
  logic         err_o;
  logic [15:0]  stall_cnt_o;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] addr_tab [3] = '{32'hA000_0000, 32'hA000_0104, 32'hA000_0208};
  logic [31:0] data_tab [3] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
  logic [2:0]  t1_gnt   [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
  logic [2:0]  t1_rv    [6] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
  logic [2:0]  t3_gnt   [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  logic [2:0]  t3_rv    [4] = '{3'b010, 3'b100, 3'b001, 3'b010};
  logic [2:0]  t4_rv    [3] = '{3'b100, 3'b001, 3'b010};
  logic [31:0] t4_data  [3] = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};

  mem_arb_rr #(
    .NumInp   (3),
    .AddrWidth(32),
    .DataWidth(32),
    .MaxTrans (4)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .inp_req_i   (inp_req_i),
    .inp_gnt_o   (inp_gnt_o),
    .inp_addr_i  (inp_addr_i),
    .inp_wdata_i (inp_wdata_i),
    .inp_strb_i  (inp_strb_i),
    .inp_we_i    (inp_we_i),
    .inp_rvalid_o(inp_rvalid_o),
    .inp_rdata_o (inp_rdata_o),
    .oup_req_o   (oup_req_o),
    .oup_gnt_i   (oup_gnt_i),
    .oup_addr_o  (oup_addr_o),
    .oup_wdata_o (oup_wdata_o),
    .oup_strb_o  (oup_strb_o),
    .oup_we_o    (oup_we_o),
    .oup_rvalid_i(oup_rvalid_i),
    .oup_rdata_i (oup_rdata_i),
    .busy_o      (busy_o),
    .err_o       (err_o),
    .stall_cnt_o (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h, want %h", tag, obs, exp);
  endtask

  // Lands 1 time unit after the rising edge; inputs change here, outputs are sampled one unit later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i        = 1'b1;
    inp_req_i    = 3'b111;
    oup_gnt_i    = 1'b1;
    oup_rvalid_i = 1'b0;
    oup_rdata_i  = '0;
    inp_we_i     = 3'b101;
    for (int i = 0; i < 3; i++) begin
      inp_addr_i[i*32 +: 32]  = addr_tab[i];
      inp_wdata_i[i*32 +: 32] = data_tab[i];
      inp_strb_i[i*4 +: 4]    = 4'h1 << i;
    end
    #2;
    check("rst_oup_req", 32'(oup_req_o), 32'd0);
    check("rst_gnt", 32'(inp_gnt_o), 32'd0);
    check("rst_rvalid", 32'(inp_rvalid_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_stall", 32'(stall_cnt_o), 32'd0);
    inp_req_i = 3'b000;
    tick();
    rst_i = 1'b0;

    // Rotation 0,1,2,0,1,2 with one response per cycle after the first grant.
    inp_req_i = 3'b111;
    for (int k = 0; k < 6; k++) begin
      oup_rvalid_i = (k != 0);
      oup_rdata_i  = 32'h5000_0000 + 32'(k);
      #1;
      check($sformatf("rot_gnt%0d", k), 32'(inp_gnt_o), 32'(t1_gnt[k]));
      check($sformatf("rot_rv%0d", k), 32'(inp_rvalid_o), 32'(t1_rv[k]));
      if (k == 0) begin
        check("rot_addr0", oup_addr_o, 32'hA000_0000);
        check("rot_wdata0", oup_wdata_o, 32'h1111_1111);
        check("rot_strb0", 32'(oup_strb_o), 32'h1);
        check("rot_we0", 32'(oup_we_o), 32'd1);
        check("rot_busy0", 32'(busy_o), 32'd0);
      end else begin
        check($sformatf("rot_rdata%0d", k), inp_rdata_o, 32'h5000_0000 + 32'(k));
        check($sformatf("rot_busy%0d", k), 32'(busy_o), 32'd1);
      end
      tick();
    end
    inp_req_i    = 3'b000;
    oup_rvalid_i = 1'b1;
    #1;
    check("rot_drain_rv", 32'(inp_rvalid_o), 32'b100);
    check("rot_drain_req", 32'(oup_req_o), 32'd0);
    tick();
    oup_rvalid_i = 1'b0;
    #1;
    check("rot_idle_busy", 32'(busy_o), 32'd0);
    check("rot_idle_err", 32'(err_o), 32'd0);

    // Stalled grant locks onto requester 1 even when requester 0 joins.
    tick();
    inp_req_i = 3'b110;
    oup_gnt_i = 1'b0;
    for (int s = 0; s < 3; s++) begin
      if (s == 1) inp_req_i = 3'b111;
      #1;
      check($sformatf("lock_req%0d", s), 32'(oup_req_o), 32'd1);
      check($sformatf("lock_gnt%0d", s), 32'(inp_gnt_o), 32'd0);
      check($sformatf("lock_addr%0d", s), oup_addr_o, 32'hA000_0104);
      tick();
    end
    oup_gnt_i = 1'b1;
    #1;
    check("lock_gnt_hit", 32'(inp_gnt_o), 32'b010);
    check("lock_addr_hit", oup_addr_o, 32'hA000_0104);
    check("lock_we_hit", 32'(oup_we_o), 32'd0);
    tick();
    inp_req_i = 3'b110;
    #1;
    check("lock_next_gnt", 32'(inp_gnt_o), 32'b100);
    check("lock_next_addr", oup_addr_o, 32'hA000_0208);
    tick();
    inp_req_i    = 3'b000;
    oup_gnt_i    = 1'b0;
    oup_rvalid_i = 1'b1;
    oup_rdata_i  = 32'h0000_1234;
    #1;
    check("lock_rv1", 32'(inp_rvalid_o), 32'b010);
    check("lock_rdata1", inp_rdata_o, 32'h0000_1234);
    tick();
    #1;
    check("lock_rv2", 32'(inp_rvalid_o), 32'b100);
    tick();
    oup_rvalid_i = 1'b0;
    #1;
    check("lock_busy", 32'(busy_o), 32'd0);

    // Fill to MaxTrans, then one response frees a slot only from the next cycle.
    tick();
    inp_req_i = 3'b111;
    oup_gnt_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("full_gnt%0d", k), 32'(inp_gnt_o), 32'(t3_gnt[k]));
      tick();
    end
    #1;
    check("full_req", 32'(oup_req_o), 32'd0);
    check("full_gnt", 32'(inp_gnt_o), 32'd0);
    check("full_busy", 32'(busy_o), 32'd1);
    tick();
    oup_rvalid_i = 1'b1;
    oup_rdata_i  = 32'hDEAD_BEEF;
    #1;
    check("full_rv", 32'(inp_rvalid_o), 32'b001);
    check("full_rdata", inp_rdata_o, 32'hDEAD_BEEF);
    check("full_nofall_req", 32'(oup_req_o), 32'd0);
    check("full_nofall_gnt", 32'(inp_gnt_o), 32'd0);
    tick();
    oup_rvalid_i = 1'b0;
    #1;
    check("full_fifth_req", 32'(oup_req_o), 32'd1);
    check("full_fifth_gnt", 32'(inp_gnt_o), 32'b010);
    tick();
    inp_req_i    = 3'b000;
    oup_gnt_i    = 1'b0;
    oup_rvalid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("full_drain%0d", k), 32'(inp_rvalid_o), 32'(t3_rv[k]));
      tick();
    end
    oup_rvalid_i = 1'b0;
    #1;
    check("full_busy_end", 32'(busy_o), 32'd0);

    // Grants 2,0,1 then in-order responses A,B,C after idle cycles.
    tick();
    inp_req_i = 3'b111;
    oup_gnt_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("il_gnt%0d", k), 32'(inp_gnt_o), 32'(t4_rv[k]));
      tick();
    end
    inp_req_i = 3'b000;
    oup_gnt_i = 1'b0;
    tick();
    tick();
    #1;
    check("il_idle_rv", 32'(inp_rvalid_o), 32'd0);
    check("il_idle_busy", 32'(busy_o), 32'd1);
    tick();
    oup_rvalid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      oup_rdata_i = t4_data[k];
      #1;
      check($sformatf("il_rv%0d", k), 32'(inp_rvalid_o), 32'(t4_rv[k]));
      check($sformatf("il_rdata%0d", k), inp_rdata_o, t4_data[k]);
      check($sformatf("il_busy%0d", k), 32'(busy_o), 32'd1);
      tick();
    end
    oup_rvalid_i = 1'b0;
    #1;
    check("il_busy_end", 32'(busy_o), 32'd0);
    check("il_err", 32'(err_o), 32'd0);

    // Unmatched response, simultaneous push with empty FIFO, then reset with two outstanding.
    tick();
    oup_rvalid_i = 1'b1;
    #1;
    check("err_rv", 32'(inp_rvalid_o), 32'd0);
    check("err_pre", 32'(err_o), 32'd0);
    tick();
    oup_rvalid_i = 1'b0;
    #1;
    check("err_set", 32'(err_o), 32'd1);
    tick();
    #1;
    check("err_hold", 32'(err_o), 32'd1);
    tick();
    inp_req_i    = 3'b111;
    oup_gnt_i    = 1'b1;
    oup_rvalid_i = 1'b1;
    #1;
    check("sim_gnt", 32'(inp_gnt_o), 32'b100);
    check("sim_rv", 32'(inp_rvalid_o), 32'd0);
    tick();
    oup_rvalid_i = 1'b0;
    #1;
    check("sim_busy", 32'(busy_o), 32'd1);
    check("sim_gnt2", 32'(inp_gnt_o), 32'b001);
    tick();
    rst_i = 1'b1;
    #1;
    check("mrst_busy", 32'(busy_o), 32'd0);
    check("mrst_err", 32'(err_o), 32'd0);
    check("mrst_req", 32'(oup_req_o), 32'd0);
    check("mrst_gnt", 32'(inp_gnt_o), 32'd0);
    tick();
    rst_i        = 1'b0;
    inp_req_i    = 3'b000;
    oup_gnt_i    = 1'b0;
    oup_rvalid_i = 1'b1;
    #1;
    check("late_rv1", 32'(inp_rvalid_o), 32'd0);
    tick();
    #1;
    check("late_err1", 32'(err_o), 32'd1);
    check("late_rv2", 32'(inp_rvalid_o), 32'd0);
    tick();
    oup_rvalid_i = 1'b0;
    #1;
    check("late_err2", 32'(err_o), 32'd1);
    check("late_busy", 32'(busy_o), 32'd0);

    // Stall counter: saturates when enabled, tied to zero otherwise.
    inp_req_i = 3'b001;
    oup_gnt_i = 1'b0;
`ifdef COMMON_CELLS_MEM_ARB_STALL_CNT_EN
    repeat (70000) tick();
    check("stall_sat", 32'(stall_cnt_o), 32'h0000_FFFF);
`else
    repeat (8) tick();
    check("stall_off", 32'(stall_cnt_o), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
